pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle instruction sequencer that owns the program counter's control inputs. It fetches from instruction memory through a req/ack handshake, latches the instruction register, and waits for the execute stage. It then issues exactly one PC update command per instruction: sequential advance, short branch, or absolute jump. It sits between the `pc` register, instruction memory and the execute/decode logic, and is the only driver of `load_pc`, `data_in`, `offset` and `branch`.

## Interface
- `word_size`, 16, PC/instruction width
- `mem_size`, 8, branch target width
- `offset_size`, 4, PC offset width
- `TIMEOUT`, 15, max FETCH cycles without `mem_ack` (only with `PCSEQ_TIMEOUT_EN`)

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous active-low reset
- `run` in 1: level, start/continue sequencing
- `pc_counter` in word_size: current PC value from `pc`
- `mem_req` out 1: fetch request
- `mem_addr` out word_size: fetch address
- `mem_ack` in 1: fetch data valid
- `mem_rdata` in word_size: fetched instruction
- `ir` out word_size: instruction register
- `ir_valid` out 1: one-cycle pulse, `ir` newly loaded
- `exec_done` in 1: execute stage finished
- `jump` in 1: absolute jump request, sampled with `exec_done`
- `jump_addr` in word_size: jump target
- `br_taken` in 1: branch taken, sampled with `exec_done`
- `br_addr` in mem_size: branch target
- `halt` in 1: stop after current instruction, sampled with `exec_done`
- `load_pc` out 1: to `pc`
- `data_in` out word_size: to `pc`
- `offset` out offset_size: to `pc`
- `branch` out mem_size: to `pc`
- `busy` out 1: state is not IDLE or HALTED
- `fault` out 1: sticky fetch timeout flag

## Operation
- States are IDLE, FETCH, DECODE, EXEC, UPDATE, HALTED.
- **IDLE:**
  - `run`=1 goes to FETCH.
  - Otherwise the block stays in IDLE.
- **FETCH:**
  - On entry, `mem_addr` is registered from `pc_counter`.
  - `mem_req` stays high until `mem_ack` is sampled high.
  - In the ack cycle, `ir`<=`mem_rdata` and the state goes to DECODE.
  - An ack in the first FETCH cycle is legal.
- **DECODE:**
  - `ir_valid`=1 for exactly this one cycle.
  - Next state is EXEC.
- **EXEC:**
  - The block waits for `exec_done`. `exec_done` may be high in the first EXEC cycle.
  - In the `exec_done` cycle it registers the command, using priority halt > jump > br_taken > sequential.
  - `halt` goes to HALTED with no PC update.
  - All other commands go to UPDATE.
- **UPDATE:** one cycle that drives exactly one command.
  - Jump: `load_pc`=1, `data_in`=`jump_addr`.
  - Branch with `br_addr`≠0: `branch`=`br_addr`, `offset`=0.
  - Branch with `br_addr`=0: `load_pc`=1, `data_in`=0. This is required because `pc` ignores a zero `branch`.
  - Sequential: `offset`=1.
  - After UPDATE, the next state is FETCH if `run`=1, else IDLE.
- **HALTED:**
  - All command outputs are 0 and `busy`=0.
  - HALTED is left only by reset.
- **Command outputs:**
  - Outside UPDATE, `load_pc`, `data_in`, `offset` and `branch` are all 0. This means `pc` holds its value.
  - Never more than one of {`load_pc`, nonzero `offset`, nonzero `branch`} is active.
- **`run` deasserted mid-instruction:** the current instruction completes through UPDATE, then the block goes to IDLE.
- **Inputs ignored:** `jump`, `br_taken` and `halt` are ignored unless `exec_done`=1 in EXEC. `mem_ack` is ignored outside FETCH.

## Timing
- **Reset values:** state IDLE, plus all of the following at 0:
  - `mem_req`, `mem_addr`, `ir`, `ir_valid`
  - `load_pc`, `data_in`, `offset`, `branch`
  - `busy`, `fault`
- Reset acts immediately (asynchronous). A mid-fetch `mem_req` drops without waiting for ack.
- All outputs are registered. There are no combinational paths from input to output.
- **Minimum instruction period:** 4 cycles (FETCH, DECODE, EXEC, UPDATE), with zero memory wait and `exec_done` high in the first EXEC cycle.
- **IDLE to first request:** `run` high at edge N gives `mem_req` high after edge N.
- **PC update:** `pc_counter` changes at the edge that ends UPDATE. The following FETCH registers the new value.

## Configuration
- **With `PCSEQ_TIMEOUT_EN` defined:**
  - A counter runs while in FETCH and clears on FETCH entry.
  - If `TIMEOUT` cycles pass without `mem_ack`: `fault`<=1 (sticky), `mem_req`<=0, and the state goes to HALTED.
  - An ack in the cycle the count reaches `TIMEOUT` is honoured and wins over the fault.
- **Without it:**
  - FETCH waits indefinitely.
  - `fault` is tied 0 and no counter is instantiated.

## Test plan
- **Sequential run:**
  - Stimulus: reset, `run`=1, `mem_ack` same cycle, `exec_done` first EXEC cycle, PC starts at 0.
  - Response: `offset`=1 pulse every 4 cycles, `mem_addr` sequence 0,1,2,3, `ir_valid` one cycle per instruction.
- **Branch to nonzero target:**
  - Stimulus: `br_taken`=1, `br_addr`=0x40.
  - Response: `branch`=0x40 for one cycle with `offset`=0, next `mem_addr`=0x40.
- **Branch to zero:**
  - Stimulus: `br_taken`=1, `br_addr`=0.
  - Response: `load_pc`=1 with `data_in`=0, next `mem_addr`=0.
- **Jump with simultaneous branch:**
  - Stimulus: `jump`=1 with `jump_addr`=0x1234, and `br_taken`=1.
  - Response: `load_pc`=1 with `data_in`=0x1234, `branch` stays 0.
- **Halt with jump:**
  - Stimulus: `halt`=1 together with `jump`=1.
  - Response: no command pulse, state HALTED, `busy`=0, no further `mem_req` until reset.
- **Stall, reset and timeout:**
  - Stimulus: hold `mem_ack`=0 for 20 cycles, then reset mid-FETCH.
  - Response with `PCSEQ_TIMEOUT_EN`: `fault`=1 after 15 FETCH cycles.
  - Response without it: `mem_req` held high for all 20 cycles.
  - On reset: all outputs 0 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch / decode / execute / update sequencer that owns the pc control inputs.
// Optional fetch timeout (fault + HALTED) is built when PCSEQ_TIMEOUT_EN is defined.
module pc_sequencer #(
  parameter int unsigned word_size   = 16,
  parameter int unsigned mem_size    = 8,
  parameter int unsigned offset_size = 4,
  parameter int unsigned TIMEOUT     = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [word_size-1:0]   pc_counter,
  output logic                   mem_req,
  output logic [word_size-1:0]   mem_addr,
  input  logic                   mem_ack,
  input  logic [word_size-1:0]   mem_rdata,
  output logic [word_size-1:0]   ir,
  output logic                   ir_valid,
  input  logic                   exec_done,
  input  logic                   jump,
  input  logic [word_size-1:0]   jump_addr,
  input  logic                   br_taken,
  input  logic [mem_size-1:0]    br_addr,
  input  logic                   halt,
  output logic                   load_pc,
  output logic [word_size-1:0]   data_in,
  output logic [offset_size-1:0] offset,
  output logic [mem_size-1:0]    branch,
  output logic                   busy,
  output logic                   fault
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   mem_req_q, mem_req_d;
  logic [word_size-1:0]   mem_addr_q, mem_addr_d;
  logic [word_size-1:0]   ir_q, ir_d;
  logic                   ir_valid_q, ir_valid_d;
  logic                   load_pc_q, load_pc_d;
  logic [word_size-1:0]   data_in_q, data_in_d;
  logic [offset_size-1:0] offset_q, offset_d;
  logic [mem_size-1:0]    branch_q, branch_d;
  logic                   busy_q, busy_d;
  logic [word_size-1:0]   pc_next;

`ifdef PCSEQ_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
`endif

  // pc loads on the same edge that enters FETCH from UPDATE, so mirror its next value here
  always_comb begin
    if (load_pc_q) begin
      pc_next = data_in_q;
    end else if (branch_q != '0) begin
      pc_next = word_size'(branch_q);
    end else begin
      pc_next = pc_counter + word_size'(offset_q);
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    load_pc_d  = 1'b0;
    data_in_d  = '0;
    offset_d   = '0;
    branch_d   = '0;
`ifdef PCSEQ_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_counter;
`ifdef PCSEQ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          state_d    = S_DECODE;
        end
`ifdef PCSEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = S_HALTED;
        end else begin
          mem_req_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
`else
        else begin
          mem_req_d = 1'b1;
        end
`endif
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          if (halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_UPDATE;
            if (jump) begin
              load_pc_d = 1'b1;
              data_in_d = jump_addr;
            end else if (br_taken) begin
              // pc ignores a zero branch, so a branch to 0 becomes a load of 0
              if (br_addr != '0) begin
                branch_d = br_addr;
              end else begin
                load_pc_d = 1'b1;
              end
            end else begin
              offset_d = offset_size'(1);
            end
          end
        end
      end
      S_UPDATE: begin
        if (run) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = pc_next;
`ifdef PCSEQ_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_HALTED);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      load_pc_q  <= 1'b0;
      data_in_q  <= '0;
      offset_q   <= '0;
      branch_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      load_pc_q  <= load_pc_d;
      data_in_q  <= data_in_d;
      offset_q   <= offset_d;
      branch_q   <= branch_d;
      busy_q     <= busy_d;
    end
  end

`ifdef PCSEQ_TIMEOUT_EN
  // Fetch wait counter and sticky fault flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign load_pc  = load_pc_q;
  assign data_in  = data_in_q;
  assign offset   = offset_q;
  assign branch   = branch_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized scoreboard bench for pc_sequencer: environment pc register, memory and execute
// responders, and an instruction-level reference model feeding expected fetches/IR/commands.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam int unsigned WS = 16;
  localparam int unsigned MS = 8;
  localparam int unsigned OS = 4;
  localparam int unsigned TO = 15;

  typedef struct packed {
    logic          ld;
    logic [WS-1:0] d;
    logic [OS-1:0] o;
    logic [MS-1:0] b;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic [WS-1:0] pc_reg;
  logic          mem_req;
  logic [WS-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [WS-1:0] mem_rdata = '0;
  logic [WS-1:0] ir;
  logic          ir_valid;
  logic          exec_done = 1'b0;
  logic          jump = 1'b0;
  logic [WS-1:0] jump_addr = '0;
  logic          br_taken = 1'b0;
  logic [MS-1:0] br_addr = '0;
  logic          halt = 1'b0;
  logic          load_pc;
  logic [WS-1:0] data_in;
  logic [OS-1:0] offset;
  logic [MS-1:0] branch;
  logic          busy;
  logic          fault;

  pc_sequencer #(.word_size(WS), .mem_size(MS), .offset_size(OS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run), .pc_counter(pc_reg),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ir(ir), .ir_valid(ir_valid), .exec_done(exec_done), .jump(jump), .jump_addr(jump_addr),
    .br_taken(br_taken), .br_addr(br_addr), .halt(halt), .load_pc(load_pc), .data_in(data_in),
    .offset(offset), .branch(branch), .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            mode = 0;          // 0 main drives, 1 random, 2 back-to-back sequential
  bit            mon_en = 1'b0;
  bit            fast_chk = 1'b0;
  bit            force_halt = 1'b0;
  bit            halt_with_jump = 1'b0;
  bit            model_halted = 1'b0;
  bit            in_exec = 1'b0;
  int            exec_delay = 0;
  int            n_instr = 0;
  int            last_cmd_cyc = -1;
  logic [WS-1:0] pc_init = '0;
  logic [WS-1:0] model_pc = '0;
  logic [WS-1:0] addr_q[$];
  logic [WS-1:0] ir_exp_q[$];
  cmd_t          cmd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got nothing expected an event (cycle %0d)", name, cyc);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mem_req"},  64'(mem_req),  64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_ir"},       64'(ir),       64'd0);
    check({tag, "_ir_valid"}, 64'(ir_valid), 64'd0);
    check({tag, "_load_pc"},  64'(load_pc),  64'd0);
    check({tag, "_data_in"},  64'(data_in),  64'd0);
    check({tag, "_offset"},   64'(offset),   64'd0);
    check({tag, "_branch"},   64'(branch),   64'd0);
    check({tag, "_busy"},     64'(busy),     64'd0);
    check({tag, "_fault"},    64'(fault),    64'd0);
  endtask

  // Reference model: one instruction's command and resulting fetch address from the priority rules
  task automatic issue_cmd();
    cmd_t          c;
    logic [WS-1:0] nxt;
    int            r;
    r         = int'($urandom_range(0, 9));
    exec_done = 1'b1;
    jump_addr = WS'($urandom);
    br_addr   = ($urandom_range(0, 2) == 0) ? MS'(0) : (($urandom_range(0, 3) == 0) ? 8'h40 : MS'($urandom));
    if (mode == 2) begin
      jump = 1'b0; br_taken = 1'b0; halt = 1'b0;
    end else begin
      jump     = (r < 3);
      br_taken = (r < 3) ? 1'($urandom) : (r < 6);
      halt     = force_halt;
      if (force_halt) jump = halt_with_jump;
    end
    if (halt) begin
      model_halted = 1'b1;
    end else begin
      if (jump) begin
        c = '{1'b1, jump_addr, OS'(0), MS'(0)}; nxt = jump_addr;
      end else if (br_taken && br_addr != 0) begin
        c = '{1'b0, WS'(0), OS'(0), br_addr}; nxt = WS'(br_addr);
      end else if (br_taken) begin
        c = '{1'b1, WS'(0), OS'(0), MS'(0)}; nxt = WS'(0);
      end else begin
        c = '{1'b0, WS'(0), OS'(1), MS'(0)}; nxt = model_pc + WS'(1);
      end
      cmd_q.push_back(c);
      addr_q.push_back(nxt);
      model_pc = nxt;
      n_instr++;
    end
  endtask

  // Environment pc register obeying the command outputs
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_reg <= pc_init;
    else if (load_pc) pc_reg <= data_in;
    else if (branch != 0) pc_reg <= WS'(branch);
    else pc_reg <= pc_reg + WS'(offset);
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory / execute responder, decides inputs for the coming edge
  always @(negedge clk) begin
    if (mode == 0) begin
      in_exec = 1'b0;
    end else begin
      run = (mode == 2) || ($urandom_range(0, 7) != 0);
      mem_rdata = WS'($urandom);
      if (mem_req) begin
        mem_ack = (mode == 2) || ($urandom_range(0, 2) != 0);
        if (mem_ack) ir_exp_q.push_back(mem_rdata);
      end else begin
        mem_ack = ($urandom_range(0, 3) == 0);
      end
      if (in_exec && exec_delay == 0) begin
        issue_cmd();
        in_exec = 1'b0;
      end else begin
        if (in_exec) exec_delay--;
        exec_done = !in_exec && (mode == 1) && ($urandom_range(0, 3) == 0);
        jump      = 1'($urandom);
        br_taken  = 1'($urandom);
        halt      = 1'($urandom);
        jump_addr = WS'($urandom);
        br_addr   = MS'($urandom);
        if (ir_valid) begin
          in_exec    = 1'b1;
          exec_delay = (mode == 2) ? 0 : int'($urandom_range(0, 3));
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a fetch, an IR or a command
  always @(negedge clk) begin
    cmd_t cur;
    #1;
    if (rst && mon_en) begin
      if (mem_req && mem_ack) begin
        if (addr_q.size() == 0) fail_now("fetch_addr_unexpected");
        else check("fetch_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      if (ir_valid) begin
        if (ir_exp_q.size() == 0) fail_now("ir_unexpected");
        else check("ir", 64'(ir), 64'(ir_exp_q.pop_front()));
      end
      cur = '{load_pc, data_in, offset, branch};
      if (cur != '0) begin
        if (cmd_q.size() == 0) fail_now("spurious_cmd");
        else check("cmd", 64'(cur), 64'(cmd_q.pop_front()));
        if (fast_chk && last_cmd_cyc >= 0) check("period", 64'(cyc - last_cmd_cyc), 64'd4);
        last_cmd_cyc = cyc;
      end
    end
  end

  task automatic wait_instr(input int target);
    int guard = 0;
    while (n_instr < target && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    if (n_instr < target) fail_now("instr_budget");
  endtask

  task automatic halt_and_check(input string tag);
    int guard = 0;
    force_halt = 1'b1;
    while (!model_halted && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    if (!model_halted) fail_now({tag, "_halt_budget"});
    force_halt = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_busy"},      64'(busy),             64'd0);
    check({tag, "_mem_req"},   64'(mem_req),          64'd0);
    check({tag, "_fault"},     64'(fault),            64'd0);
    check({tag, "_cmd_left"},  64'(cmd_q.size()),     64'd0);
    check({tag, "_addr_left"}, 64'(addr_q.size()),    64'd0);
    check({tag, "_ir_left"},   64'(ir_exp_q.size()),  64'd0);
  endtask

  initial begin
    logic [2:0] exp;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    @(negedge clk) rst = 1'b1;

    // back-to-back sequential instructions from pc 0
    model_pc = '0;
    addr_q.push_back('0);
    fast_chk = 1'b1;
    mon_en   = 1'b1;
    @(posedge clk);
    #2 mode = 2;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("first_req",  64'(mem_req),  64'd1);
    check("first_addr", 64'(mem_addr), 64'd0);
    check("first_busy", 64'(busy),     64'd1);
    wait_instr(6);

    // random traffic, then halt together with jump
    @(posedge clk);
    #2 fast_chk = 1'b0;
    mode = 1;
    wait_instr(70);
    halt_with_jump = 1'b1;
    halt_and_check("halt_jump");

    // stalled fetch and asynchronous reset
    mode = 0;
    pc_init = 16'h0100;
    #2 rst = 1'b0;
    #1 check_reset("halted_rst");
    model_halted = 1'b0;
    run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; halt = 1'b0; jump = 1'b0; br_taken = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) run = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
`ifdef PCSEQ_TIMEOUT_EN
      exp = (k <= int'(TO)) ? 3'b101 : 3'b010;
`else
      exp = 3'b101;
`endif
      check("stall_req_fault_busy", 64'({mem_req, fault, busy}), 64'(exp));
    end
    check("stall_addr", 64'(mem_addr), 64'h0100);
    #3 rst = 1'b0;
    #1 check_reset("fetch_rst");

    // second random run from a random start pc, plain halt
    pc_init = WS'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    model_pc = pc_init;
    addr_q.push_back(pc_init);
    n_instr = 0;
    last_cmd_cyc = -1;
    @(posedge clk);
    #2 mode = 1;
    wait_instr(50);
    halt_with_jump = 1'b0;
    halt_and_check("halt_plain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish within 100000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
